// File: rtl/mode_ctrl_if.sv
// Switch/button inputs and mode outputs of the run/pause/adjust mode controller.
interface mode_ctrl_if;
   logic sw_adj;
   logic sw_sel;
   logic btn_pause;
   logic btn_clr;
   logic reg_mode;
   logic adj_sec_mode;
   logic adj_min_mode;
   logic pause_mode;
   logic clr_pulse;

   modport master (
      output sw_adj, sw_sel, btn_pause, btn_clr,
      input  reg_mode, adj_sec_mode, adj_min_mode, pause_mode, clr_pulse
   );

   modport slave (
      input  sw_adj, sw_sel, btn_pause, btn_clr,
      output reg_mode, adj_sec_mode, adj_min_mode, pause_mode, clr_pulse
   );
endinterface

// File: rtl/mode_ctrl.sv
// Mode controller: synchronizes and debounces two switches and two buttons,
// then sequences RUN / PAUSED / ADJ_SEC / ADJ_MIN with a sticky paused flag.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   RUN     | counter advances at 1 Hz
//   PAUSED  | counter frozen (paused flag = 1)
//   ADJ_SEC | adjust switch on, seconds selected
//   ADJ_MIN | adjust switch on, minutes selected
module mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   mode_ctrl_if.slave  bus
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {RUN, PAUSED, ADJ_SEC, ADJ_MIN} state_t;

   // bit order: 0 sw_adj, 1 sw_sel, 2 btn_pause, 3 btn_clr
   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    deb;
   logic [3:0]    lvl_q;
   logic [CW-1:0] cnt [4];
   logic          pause_press;
   logic          clr_press;

   state_t state, state_nxt;
   logic   paused, paused_nxt;
   logic   clr_pulse_q;

   assign raw = {bus.btn_clr, bus.btn_pause, bus.sw_sel, bus.sw_adj};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= '0;
         sync2       <= '0;
         deb         <= '0;
         lvl_q       <= '0;
         pause_press <= 1'b0;
         clr_press   <= 1'b0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
         // Levels and press events are both registered so every input sees
         // the same pipeline depth into the state register.
         lvl_q       <= deb;
         pause_press <= deb[2] & ~lvl_q[2];
         clr_press   <= deb[3] & ~lvl_q[3];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         paused      <= 1'b0;
         clr_pulse_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         paused      <= paused_nxt;
         clr_pulse_q <= clr_press;
      end
   end

   always_comb begin
      state_nxt  = state;
      paused_nxt = paused;
      if (lvl_q[0]) begin
         // Adjust entry/hold has priority; a coincident pause press is dropped.
         state_nxt = lvl_q[1] ? ADJ_SEC : ADJ_MIN;
      end else begin
         case (state)
            RUN: begin
               if (pause_press) begin
                  state_nxt  = PAUSED;
                  paused_nxt = 1'b1;
               end
            end
            PAUSED: begin
               if (pause_press) begin
                  state_nxt  = RUN;
                  paused_nxt = 1'b0;
               end
            end
            ADJ_SEC, ADJ_MIN: state_nxt = paused ? PAUSED : RUN;
            default:          state_nxt = RUN;
         endcase
      end
   end

   assign bus.reg_mode     = (state == RUN);
   assign bus.pause_mode   = (state == PAUSED);
   assign bus.adj_sec_mode = (state == ADJ_SEC);
   assign bus.adj_min_mode = (state == ADJ_MIN);
   assign bus.clr_pulse    = clr_pulse_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Scenario bench for mode_ctrl with DEBOUNCE_CYCLES=4; expected mode steps
// are queued with their due cycle when stimulus is applied.
module tb_mode_ctrl;
   localparam int N   = 4;
   localparam int LAT = N + 4;   // negedge drive -> change seen at negedge

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {logic [3:0] m; int c;} exp_t;
   exp_t sb[$];

   mode_ctrl_if bus();

   mode_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // {reg, adj_sec, adj_min, pause}
   wire [3:0] modes = {bus.reg_mode, bus.adj_sec_mode, bus.adj_min_mode, bus.pause_mode};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      tests++;
      if ($countones(modes) != 1) begin
         fails++;
         $display("FAIL onehot: modes=%b at cyc %0d, required exactly one bit set", modes, cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1);
   end

   task automatic wait_change(input int max_cyc, output bit got, output logic [3:0] v, output int c);
      logic [3:0] prev;
      prev = modes;
      got  = 1'b0;
      v    = modes;
      c    = cyc;
      for (int i = 0; i < max_cyc && !got; i++) begin
         @(negedge clk);
         if (modes !== prev) begin
            got = 1'b1;
            v   = modes;
            c   = cyc;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      bit bad;
      bus.sw_adj = 0; bus.sw_sel = 0; bus.btn_pause = 0; bus.btn_clr = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (modes !== 4'b1000 || bus.clr_pulse !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: modes=%b clr=%b, required modes=1000 clr=0", modes, bus.clr_pulse);
      end
      rst = 1'b0;
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (modes !== 4'b1000 || bus.clr_pulse !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL reset_idle: modes=%b clr=%b, required modes=1000 clr=0 throughout", modes, bus.clr_pulse);
      end
   endtask

   task automatic test_pause_toggle();
      bit got; logic [3:0] v; int c, k; exp_t e;
      @(negedge clk);
      bus.btn_pause = 1; k = cyc;
      sb.push_back('{m: 4'b0001, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL pause_on: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      while (cyc < k + 20) @(negedge clk);
      bus.btn_pause = 0;
      wait_change(15, got, v, c);
      tests++;
      if (got) begin
         fails++;
         $display("FAIL pause_release: modes=%b at cyc %0d, required no change", v, c);
      end
      bus.btn_pause = 1; k = cyc;
      sb.push_back('{m: 4'b1000, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL pause_off: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      while (cyc < k + 12) @(negedge clk);
      bus.btn_pause = 0;
      idle(12);
   endtask

   task automatic test_glitch();
      bit bad;
      bad = 1'b0;
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 3; j++) begin
            bus.btn_pause = 1;
            @(negedge clk);
            if (modes !== 4'b1000) bad = 1'b1;
         end
         bus.btn_pause = 0;
         @(negedge clk);
         if (modes !== 4'b1000) bad = 1'b1;
      end
      repeat (12) begin
         @(negedge clk);
         if (modes !== 4'b1000) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL glitch: modes=%b, required 1000 throughout", modes);
      end
   endtask

   task automatic test_adjust();
      bit got; logic [3:0] v; int c, k, n_clr, first_clr; bit mode_bad; exp_t e;
      bus.btn_pause = 1; k = cyc;
      sb.push_back('{m: 4'b0001, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL adj_pre_pause: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      while (cyc < k + 10) @(negedge clk);
      bus.btn_pause = 0;
      idle(12);

      bus.sw_adj = 1; bus.sw_sel = 0; k = cyc;
      sb.push_back('{m: 4'b0010, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL adj_min: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end

      bus.sw_sel = 1; k = cyc;
      sb.push_back('{m: 4'b0100, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL adj_sec: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end

      bus.btn_pause = 1;
      idle(10);
      bus.btn_pause = 0;
      wait_change(25, got, v, c);
      tests++;
      if (got || modes !== 4'b0100) begin
         fails++;
         $display("FAIL adj_pause_ignored: modes=%b at cyc %0d, required 0100 unchanged", v, c);
      end

      bus.btn_clr = 1; k = cyc;
      sb.push_back('{m: 4'b0100, c: k + LAT});
      n_clr = 0; first_clr = -1; mode_bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (bus.clr_pulse === 1'b1) begin
            if (n_clr == 0) first_clr = cyc;
            n_clr++;
         end
         if (modes !== 4'b0100) mode_bad = 1'b1;
      end
      bus.btn_clr = 0;
      e = sb.pop_front();
      tests++;
      if (n_clr != 1 || first_clr != e.c || mode_bad) begin
         fails++;
         $display("FAIL clr_adj: pulses=%0d first at cyc %0d mode_bad=%0d, required 1 pulse at cyc %0d in modes %b",
                  n_clr, first_clr, mode_bad, e.c, e.m);
      end
      idle(12);

      bus.sw_adj = 0; k = cyc;
      sb.push_back('{m: 4'b0001, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL adj_exit_paused: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end

      bus.btn_pause = 1; k = cyc;
      sb.push_back('{m: 4'b1000, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL adj_post_resume: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      while (cyc < k + 10) @(negedge clk);
      bus.btn_pause = 0;
      bus.sw_sel = 0;
      idle(12);
   endtask

   task automatic test_back_to_back();
      bit got; logic [3:0] v; int c, k, n_clr, first_clr; bit mode_bad; exp_t e;
      bus.btn_pause = 1; bus.sw_adj = 1; bus.sw_sel = 1; k = cyc;
      sb.push_back('{m: 4'b0100, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL simul_adj_wins: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      while (cyc < k + 10) @(negedge clk);
      bus.btn_pause = 0;
      idle(12);

      bus.sw_adj = 0; k = cyc;
      sb.push_back('{m: 4'b1000, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL simul_exit_run: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      bus.sw_sel = 0;
      wait_change(15, got, v, c);
      tests++;
      if (got) begin
         fails++;
         $display("FAIL simul_settle: modes=%b at cyc %0d, required 1000 unchanged", v, c);
      end

      bus.btn_clr = 1; k = cyc;
      sb.push_back('{m: 4'b1000, c: k + LAT});
      n_clr = 0; first_clr = -1; mode_bad = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus.clr_pulse === 1'b1) begin
            if (n_clr == 0) first_clr = cyc;
            n_clr++;
         end
         if (modes !== 4'b1000) mode_bad = 1'b1;
      end
      bus.btn_clr = 0;
      e = sb.pop_front();
      tests++;
      if (n_clr != 1 || first_clr != e.c || mode_bad) begin
         fails++;
         $display("FAIL clr_run: pulses=%0d first at cyc %0d mode_bad=%0d, required 1 pulse at cyc %0d in modes %b",
                  n_clr, first_clr, mode_bad, e.c, e.m);
      end
      idle(12);
   endtask

   task automatic test_reset_mid();
      bit got; logic [3:0] v; int c, k, r; exp_t e;
      bus.btn_pause = 1; k = cyc;
      sb.push_back('{m: 4'b0001, c: k + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL rmid_pause: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      while (cyc < k + 10) @(negedge clk);
      bus.btn_pause = 0;
      idle(12);

      bus.btn_pause = 1; k = cyc;
      while (cyc < k + 4) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (modes !== 4'b1000 || bus.clr_pulse !== 1'b0) begin
         fails++;
         $display("FAIL rmid_reset: modes=%b clr=%b, required modes=1000 clr=0", modes, bus.clr_pulse);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0; r = cyc;
      sb.push_back('{m: 4'b0001, c: r + LAT});
      wait_change(LAT + 4, got, v, c); e = sb.pop_front();
      tests++;
      if (!got || v !== e.m || c !== e.c) begin
         fails++;
         $display("FAIL rmid_after_release: modes=%b at cyc %0d (seen=%0d), required %b at cyc %0d", v, c, got, e.m, e.c);
      end
      bus.btn_pause = 0;
      idle(12);
   endtask

   initial begin
      test_reset();
      test_pause_toggle();
      test_glitch();
      test_adjust();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mode_ctrl.md
MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 SHALL provide parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable clk cycles required to accept a new input level (legal range 2..2^20).
REQ-002 SHALL provide port: clk  input  1  master clock; all state on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: sw_adj  input  1  raw switch; 1 = adjust requested.
REQ-005 SHALL provide port: sw_sel  input  1  raw switch; in adjust, 1 = seconds, 0 = minutes.
REQ-006 SHALL provide port: btn_pause  input  1  raw pushbutton; press toggles pause.
REQ-007 SHALL provide port: btn_clr  input  1  raw pushbutton; press requests counter clear.
REQ-008 SHALL provide port: reg_mode  output  1  counter runs at 1 Hz.
REQ-009 SHALL provide port: adj_sec_mode  output  1  seconds advance at adjust rate.
REQ-010 SHALL provide port: adj_min_mode  output  1  minutes advance at adjust rate.
REQ-011 SHALL provide port: pause_mode  output  1  counter frozen.
REQ-012 SHALL provide port: clr_pulse  output  1  one-cycle counter clear strobe.

Function
REQ-013 SHALL pass each of the four raw inputs through a two-flop synchronizer before any other use.
REQ-014 SHALL debounce each synchronized input independently: counter increments each cycle the synchronized level differs from the debounced level, clears to 0 on any cycle they agree.
REQ-015 SHALL update the debounced level and clear the counter on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle; shorter glitches SHALL have no effect.
REQ-016 SHALL generate press events for btn_pause and btn_clr only on debounced 0->1 transitions; holding a button SHALL yield exactly one event; releases yield none.
REQ-017 SHALL implement a registered FSM with states RUN, PAUSED, ADJ_SEC, ADJ_MIN plus a one-bit paused flag.
REQ-018 SHALL drive mode outputs one-hot from the state register: RUN->reg_mode, PAUSED->pause_mode, ADJ_SEC->adj_sec_mode, ADJ_MIN->adj_min_mode; exactly one high every cycle.
REQ-019 Transitions: debounced sw_adj=1 -> ADJ_SEC if debounced sw_sel=1, else ADJ_MIN, from any state.
REQ-020 Within adjust, sw_sel changes SHALL move between ADJ_SEC and ADJ_MIN directly.
REQ-021 Debounced sw_adj=0 while in adjust SHALL return to PAUSED if paused flag=1, else RUN.
REQ-022 Pause press in RUN -> PAUSED and flag=1; in PAUSED -> RUN and flag=0; in ADJ_SEC/ADJ_MIN pause press SHALL be discarded (flag unchanged).
REQ-023 Simultaneous pause press and adjust entry in the same cycle: adjust wins, pause press discarded.
REQ-024 Clear press in any state SHALL assert clr_pulse for exactly one cycle, registered, without changing state or flag.
REQ-025 Latency: a clean step on any input held stable SHALL reach the registered outputs exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the new level.
REQ-026 Debounce counters SHALL be wide enough for DEBOUNCE_CYCLES and SHALL NOT wrap.

Reset
REQ-027 While rst=1: state=RUN, flag=0, reg_mode=1, adj_sec_mode=0, adj_min_mode=0, pause_mode=0, clr_pulse=0, synchronizers, debounced levels and counters=0.
REQ-028 Reset asserted mid-debounce SHALL discard partial counts; inputs already high at reset release SHALL be accepted after full DEBOUNCE_CYCLES and, for buttons, produce a press event.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset release, inputs 0 -> reg_mode=1, all others 0 indefinitely.
REQ-030 btn_pause high 20 cycles -> pause_mode rises exactly 7 edges after first sampling edge, reg_mode falls same cycle; second press -> back to RUN.
REQ-031 btn_pause pulses of 3 cycles, repeated with 1-cycle gaps -> no mode change.
REQ-032 PAUSED, then sw_adj=1 sw_sel=0 -> adj_min_mode=1; sw_sel=1 -> adj_sec_mode=1; pause press ignored; sw_adj=0 -> pause_mode=1.
REQ-033 btn_clr held 50 cycles in ADJ_SEC -> clr_pulse high exactly one cycle, adj_sec_mode stays 1.
REQ-034 rst asserted during pause-button debounce count 2 -> reg_mode=1 immediately; no press event until 4 new stable cycles after release.
